counter_sequencer: RTL



---
 rtl/counter_sequencer_if.sv | 36 +++
 rtl/counter_sequencer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/counter_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : counter_sequencer_if
// Brief    : Control/config/status bundle between a host and counter_sequencer.
//            The host drives requests and configuration; the sequencer
//            returns count and status.
// Revision : 1.0 - initial release
// ============================================================================
interface counter_sequencer_if #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 4
);
    logic                  start;
    logic                  stop;
    logic                  pause;
    logic [WIDTH-1:0]      cfg_period;
    logic [PRESCALE_W-1:0] cfg_prescale;
    logic                  cfg_reload;
    logic                  irq_ack;
    logic [WIDTH-1:0]      count;
    logic                  busy;
    logic                  tick;
    logic                  irq;
    logic [1:0]            state;

    modport master (
        output start, stop, pause, cfg_period, cfg_prescale, cfg_reload, irq_ack,
        input  count, busy, tick, irq, state
    );

    modport slave (
        input  start, stop, pause, cfg_period, cfg_prescale, cfg_reload, irq_ack,
        output count, busy, tick, irq, state
    );
endinterface
`default_nettype wire

// File: rtl/counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : counter_sequencer
// Brief    : Prescaled period counter with one-shot / auto-reload modes,
//            pause/resume, abort, terminal-count tick and sticky interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module counter_sequencer #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    counter_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam logic [WIDTH-1:0]      C_CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PRESCALE_W-1:0] C_PRE_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    state_t                r_state;
    logic [WIDTH-1:0]      r_count;
    logic [PRESCALE_W-1:0] r_presc;
    logic                  r_tick;
    logic                  r_irq;
    logic [WIDTH-1:0]      r_period;
    logic [PRESCALE_W-1:0] r_prescale;
    logic                  r_reload;

    state_t                w_state_nx;
    logic [WIDTH-1:0]      w_count_nx;
    logic [PRESCALE_W-1:0] w_presc_nx;
    logic                  w_tick_nx;
    logic                  w_irq_nx;
    logic                  w_latch;

    // Register all state; reset clears everything including the latched config.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_presc    <= '0;
            r_tick     <= 1'b0;
            r_irq      <= 1'b0;
            r_period   <= '0;
            r_prescale <= '0;
            r_reload   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_count <= w_count_nx;
            r_presc <= w_presc_nx;
            r_tick  <= w_tick_nx;
            r_irq   <= w_irq_nx;
            if (w_latch) begin
                r_period   <= bus.cfg_period;
                r_prescale <= bus.cfg_prescale;
                r_reload   <= bus.cfg_reload;
            end
        end
    end

    // Next-state and datapath decisions; stop dominates every other request.
    always_comb begin
        w_state_nx = r_state;
        w_count_nx = r_count;
        w_presc_nx = r_presc;
        w_tick_nx  = 1'b0;
        // A terminal step below overrides this, so a coincident set beats ack.
        w_irq_nx   = r_irq & ~bus.irq_ack;
        w_latch    = 1'b0;

        if (bus.stop) begin
            w_state_nx = IDLE;
            w_count_nx = '0;
            w_presc_nx = '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        w_latch    = 1'b1;
                        w_count_nx = '0;
                        w_presc_nx = '0;
                        w_state_nx = RUN;
                    end
                end
                RUN: begin
                    if (bus.pause) begin
                        // Freeze immediately: the step on this edge is dropped.
                        w_state_nx = HOLD;
                    end else if (r_presc == r_prescale) begin
                        w_presc_nx = '0;
                        if (r_count == r_period) begin
                            w_count_nx = '0;
                            w_tick_nx  = 1'b1;
                            w_irq_nx   = 1'b1;
                            if (!r_reload) begin
                                w_state_nx = DONE;
                            end
                        end else begin
                            w_count_nx = r_count + C_CNT_ONE;
                        end
                    end else begin
                        w_presc_nx = r_presc + C_PRE_ONE;
                    end
                end
                HOLD: begin
                    if (!bus.pause) begin
                        w_state_nx = RUN;
                    end
                end
                default: begin
                    w_state_nx = IDLE;
                end
            endcase
        end
    end

    assign bus.count = r_count;
    assign bus.tick  = r_tick;
    assign bus.irq   = r_irq;
    assign bus.state = r_state;
    assign bus.busy  = (r_state == RUN) || (r_state == HOLD);

endmodule
`default_nettype wire
